// File: rtl/fib_arbiter_pkg.sv
// Shared types and defaults for the fib channel arbiter and its round-robin picker.
package fib_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PARAM  = 2'd1,
    ST_RESULT = 2'd2
  } arb_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Index width for an N-entry pointer; never zero so single-bit ports stay legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fib_arbiter_rr_pick.sv
// Cyclic first-set-bit finder: returns the first request at or after ptr, wrapping.
module rr_pick
  import fib_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  logic [N-1:0] mask_hi;
  logic [N-1:0] req_hi;
  logic [N-1:0] low_hi;
  logic [N-1:0] low_all;

  always_comb begin
    mask_hi = '0;
    for (int i = 0; i < N; i++) begin
      mask_hi[i] = (PW'(i) >= ptr);
    end
  end

  // Prefer the lowest request at or above ptr; otherwise wrap to the lowest overall.
  assign req_hi  = req & mask_hi;
  assign low_hi  = req_hi & (~req_hi + N'(1));
  assign low_all = req & (~req + N'(1));
  assign pick    = (|req_hi) ? low_hi : low_all;
  assign any     = |req;

endmodule

// File: rtl/fib_arbiter.sv
// Round-robin arbiter serialising whole param/result transactions from NUM_REQ
// requesters onto a single fib core; counts completed transactions.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no owner; pick next requester at or after ptr
//   ST_PARAM  | owner g's param channel is wired through to fib
//   ST_RESULT | fib result channel is wired through to owner g
module fib_arbiter
  import fib_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_param_data,
  input  logic [NUM_REQ-1:0]            req_param_en,
  output logic [NUM_REQ-1:0]            req_param_ack,
  output logic [DATA_WIDTH-1:0]         req_result_data,
  output logic [NUM_REQ-1:0]            req_result_en,
  input  logic [NUM_REQ-1:0]            req_result_ack,
  output logic [DATA_WIDTH-1:0]         fib_param_data,
  output logic                          fib_param_en,
  input  logic                          fib_param_ack,
  input  logic [DATA_WIDTH-1:0]         fib_result_data,
  input  logic                          fib_result_en,
  output logic                          fib_result_ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic [CNT_WIDTH-1:0]          done_count
);

  localparam int PW = ptr_width(NUM_REQ);

  arb_state_e state;
  arb_state_e state_nxt;

  logic [PW-1:0]         g;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         g_inc;
  logic [PW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    pick_oh;
  logic                  pick_any;
  logic                  withdraw;
  logic                  param_xfer;
  logic                  result_xfer;
  logic [DATA_WIDTH-1:0] param_slice [NUM_REQ];

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req  (req_param_en),
    .ptr  (ptr),
    .pick (pick_oh),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_idx = PW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      param_slice[i] = req_param_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign g_inc = (g == PW'(NUM_REQ - 1)) ? '0 : g + PW'(1);

  // A dropped param_en while owning the channel abandons the transaction.
  assign withdraw    = (state == ST_PARAM) && !req_param_en[g];
  assign param_xfer  = (state == ST_PARAM) && req_param_en[g] && fib_param_ack;
  assign result_xfer = (state == ST_RESULT) && fib_result_en && req_result_ack[g];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_any) state_nxt = ST_PARAM;
      end
      ST_PARAM: begin
        if (withdraw)        state_nxt = ST_IDLE;
        else if (param_xfer) state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        if (result_xfer) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fib_param_en    = 1'b0;
    fib_param_data  = '0;
    req_param_ack   = '0;
    req_result_en   = '0;
    req_result_data = '0;
    fib_result_ack  = 1'b0;
    case (state)
      ST_PARAM: begin
        fib_param_en     = req_param_en[g];
        fib_param_data   = param_slice[g];
        req_param_ack[g] = fib_param_ack;
      end
      ST_RESULT: begin
        req_result_en[g] = fib_result_en;
        req_result_data  = fib_result_data;
        fib_result_ack   = req_result_ack[g];
      end
      default: ;
    endcase
  end

  // Owner, rotation pointer and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      g          <= '0;
      ptr        <= '0;
      grant      <= '0;
      done_count <= '0;
    end else begin
      if ((state == ST_IDLE) && pick_any) begin
        g     <= pick_idx;
        grant <= pick_oh;
      end else if (withdraw || result_xfer) begin
        grant <= '0;
        ptr   <= g_inc;
      end
      if (result_xfer) done_count <= done_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fib_arbiter.sv
// Scoreboard bench for fib_arbiter with a behavioural fib core attached to the fib side.
module tb_fib_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] req_param_data;
  logic [N-1:0]    req_param_en;
  logic [N-1:0]    req_param_ack;
  logic [DW-1:0]   req_result_data;
  logic [N-1:0]    req_result_en;
  logic [N-1:0]    req_result_ack;
  logic [DW-1:0]   fib_param_data;
  logic            fib_param_en;
  logic            fib_param_ack;
  logic [DW-1:0]   fib_result_data;
  logic            fib_result_en;
  logic            fib_result_ack;
  logic [N-1:0]    grant;
  logic [CW-1:0]   done_count;

  int checks   = 0;
  int failures = 0;

  fib_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_param_data  (req_param_data),
    .req_param_en    (req_param_en),
    .req_param_ack   (req_param_ack),
    .req_result_data (req_result_data),
    .req_result_en   (req_result_en),
    .req_result_ack  (req_result_ack),
    .fib_param_data  (fib_param_data),
    .fib_param_en    (fib_param_en),
    .fib_param_ack   (fib_param_ack),
    .fib_result_data (fib_result_data),
    .fib_result_en   (fib_result_en),
    .fib_result_ack  (fib_result_ack),
    .grant           (grant),
    .done_count      (done_count)
  );

  always #5 clk = ~clk;

  function automatic int fib_ref(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural fib core: accepts one param, computes for 2..5 cycles, holds result until acked.
  logic        f_busy    = 1'b0;
  logic        f_valid   = 1'b0;
  logic        fib_stall = 1'b0;
  int          f_cnt     = 0;
  logic [DW-1:0] f_data  = '0;
  int          fib_accepts = 0;

  assign fib_param_ack   = !f_busy && !f_valid && !fib_stall;
  assign fib_result_en   = f_valid;
  assign fib_result_data = f_valid ? f_data : '0;

  always @(posedge clk) begin
    if (rst) begin
      f_busy  <= 1'b0;
      f_valid <= 1'b0;
      f_cnt   <= 0;
    end else if (fib_param_en && fib_param_ack) begin
      f_busy      <= 1'b1;
      f_cnt       <= 2 + int'(fib_param_data[1:0]);
      f_data      <= DW'(fib_ref(int'(fib_param_data)));
      fib_accepts <= fib_accepts + 1;
    end else if (f_busy) begin
      if (f_cnt == 0) begin
        f_busy  <= 1'b0;
        f_valid <= 1'b1;
      end else begin
        f_cnt <= f_cnt - 1;
      end
    end else if (f_valid && fib_result_ack) begin
      f_valid <= 1'b0;
    end
  end

  typedef struct {
    int r;
    int v;
  } exp_t;

  exp_t exp_q[$];
  int   served_r[$];
  int   served_v[$];

  int          model_ptr  = 0;
  int          exp_done   = 0;
  int          mon_hit;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] snap       = '0;

  function automatic logic [N-1:0] rr_ref(input logic [N-1:0] req, input int p);
    logic [N-1:0] res;
    res = '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (req[i] && res == '0) res[i] = 1'b1;
    end
    return res;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Monitor: samples mid-cycle; a transfer seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_ptr  = 0;
      exp_done   = 0;
      prev_grant = '0;
      snap       = '0;
    end else begin
      check("done_count", 64'(done_count), 64'(exp_done % 65536));
      if (grant != '0) begin
        check("grant_gating",
              64'({$countones(grant) == 1, (req_param_ack & ~grant) == '0, (req_result_en & ~grant) == '0}),
              64'(3'b111));
        if (prev_grant == '0) check("arb_winner", 64'(grant), 64'(rr_ref(snap, model_ptr)));
        else                  check("grant_stable", 64'(grant), 64'(prev_grant));
      end else begin
        if (prev_grant != '0) model_ptr = (oh_idx(prev_grant) + 1) % N;
        check("idle_outputs", 64'({req_param_ack, req_result_en, fib_param_en, fib_result_ack}), 64'(0));
        snap = req_param_en;
      end
      for (int r = 0; r < N; r++) begin
        if (req_result_en[r] && req_result_ack[r]) begin
          mon_hit = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (mon_hit < 0 && exp_q[i].r == r) mon_hit = i;
          end
          if (mon_hit < 0) begin
            checks++;
            failures++;
            $display("FAIL result_unexpected: req %0d got %0h expected none", r, req_result_data);
          end else begin
            check("result_data", 64'(req_result_data), 64'(exp_q[mon_hit].v));
            exp_q.delete(mon_hit);
          end
          served_r.push_back(r);
          served_v.push_back(int'(req_result_data));
          exp_done++;
        end
      end
      prev_grant = grant;
    end
  end

  task automatic send(input int r, input int n);
    exp_t e;
    e.r = r;
    e.v = fib_ref(n);
    exp_q.push_back(e);
    req_param_data[r*DW +: DW] = DW'(n);
    req_param_en[r] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (req_param_ack[r]) begin
        @(posedge clk);
        #1;
        req_param_en[r] = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL param_timeout: req %0d no ack within 300 cycles", r);
    req_param_en[r] = 1'b0;
  endtask

  task automatic send_if(input logic [N-1:0] mask, input int r, input int n);
    if (mask[r]) send(r, n);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (grant == '0 && exp_q.size() == 0 && req_param_en == '0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout: still busy after 1000 cycles, pending %0d", name, exp_q.size());
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_param_en = '0;
    fib_stall    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    served_r.delete();
    served_v.delete();
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, 64'({grant, req_param_ack, req_result_en, fib_param_en, fib_result_ack}), 64'(0));
    check({name, "_data"}, 64'({req_result_data, fib_param_data}), 64'(0));
    check({name, "_count"}, 64'(done_count), 64'(0));
  endtask

  logic [N-1:0] mask;
  int           nv [N];
  int           gap;
  int           acc0;
  logic         rand_ack = 1'b0;
  int           simul_v [4] = '{0, 1, 1, 2};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    req_param_data = '0;
    req_param_en   = '0;
    req_result_ack = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single request
    send(0, 6);
    check("single_grant", 64'(grant), 64'(4'b0001));
    wait_drain("single");
    check("single_served", 64'(served_r.size() == 1 ? served_r[0] : -1), 64'(0));
    check("single_value", 64'(served_v.size() == 1 ? served_v[0] : -1), 64'(8));
    check("single_done", 64'(done_count), 64'(1));

    // all four at once
    do_reset();
    fork
      send(0, 0);
      send(1, 1);
      send(2, 2);
      send(3, 3);
    join
    wait_drain("simul");
    check("simul_count", 64'(served_r.size()), 64'(4));
    for (int i = 0; i < served_r.size() && i < 4; i++) begin
      check("simul_order", 64'(served_r[i]), 64'(i));
      check("simul_value", 64'(served_v[i]), 64'(simul_v[i]));
    end
    check("simul_done", 64'(done_count), 64'(4));

    // rotation after requester 2
    do_reset();
    send(2, 4);
    wait_drain("rot_a");
    served_r.delete();
    served_v.delete();
    fork
      send(1, 5);
      send(3, 6);
    join
    wait_drain("rot_b");
    check("rot_first", 64'(served_r.size() > 0 ? served_r[0] : -1), 64'(3));
    check("rot_second", 64'(served_r.size() > 1 ? served_r[1] : -1), 64'(1));

    // result backpressure on requester 1 with requester 2 waiting
    served_r.delete();
    served_v.delete();
    req_result_ack[1] = 1'b0;
    send(1, 5);
    fork
      send(2, 3);
    join_none
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_hold", 64'({fib_result_ack, grant, req_param_ack[2]}), 64'({1'b0, 4'b0010, 1'b0}));
    end
    check("bp_result_en", 64'(req_result_en), 64'(4'b0010));
    @(posedge clk);
    #1;
    req_result_ack[1] = 1'b1;
    wait_drain("bp");
    check("bp_first", 64'(served_r.size() > 0 ? served_r[0] : -1), 64'(1));
    check("bp_value", 64'(served_v.size() > 0 ? served_v[0] : -1), 64'(5));
    check("bp_second", 64'(served_r.size() > 1 ? served_r[1] : -1), 64'(2));

    // withdrawal in PARAM
    do_reset();
    acc0 = fib_accepts;
    fib_stall = 1'b1;
    req_param_data[DW-1:0] = DW'(9);
    req_param_en[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wd_grant", 64'(grant), 64'(4'b0001));
    check("wd_fib_en", 64'(fib_param_en), 64'(1));
    check("wd_ack", 64'(req_param_ack), 64'(0));
    @(posedge clk);
    #1;
    req_param_en[0] = 1'b0;
    @(negedge clk);
    check("wd_fib_en_drop", 64'(fib_param_en), 64'(0));
    @(negedge clk);
    check("wd_idle", 64'(grant), 64'(0));
    check("wd_done", 64'(done_count), 64'(0));
    check("wd_no_fib", 64'(fib_accepts), 64'(acc0));
    @(posedge clk);
    #1;
    fib_stall = 1'b0;
    fork
      send(0, 2);
      send(1, 3);
    join
    wait_drain("wd");
    check("wd_next_first", 64'(served_r.size() > 0 ? served_r[0] : -1), 64'(1));
    check("wd_next_second", 64'(served_r.size() > 1 ? served_r[1] : -1), 64'(0));

    // reset while in RESULT
    req_result_ack[3] = 1'b0;
    send(3, 7);
    for (int c = 0; c < 100 && !req_result_en[3]; c++) @(negedge clk);
    check("mr_in_result", 64'(req_result_en), 64'(4'b1000));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("mr_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_result_ack[3] = 1'b1;
    @(negedge clk);
    check("mr_no_stale", 64'({req_result_en, fib_result_en}), 64'(0));
    @(posedge clk);
    #1;
    served_r.delete();
    served_v.delete();
    send(3, 4);
    wait_drain("mr");
    check("mr_value", 64'(served_v.size() > 0 ? served_v[0] : -1), 64'(3));
    check("mr_done", 64'(done_count), 64'(1));

    // randomized traffic with random result backpressure
    rand_ack = 1'b1;
    fork
      begin
        while (rand_ack) begin
          @(posedge clk);
          #1;
          if (rand_ack) req_result_ack = N'($urandom);
        end
        req_result_ack = '1;
      end
    join_none
    for (int round = 0; round < 30; round++) begin
      mask = N'($urandom_range(1, 15));
      for (int r = 0; r < N; r++) nv[r] = int'($urandom_range(0, 24));
      fork
        send_if(mask, 0, nv[0]);
        send_if(mask, 1, nv[1]);
        send_if(mask, 2, nv[2]);
        send_if(mask, 3, nv[3]);
      join
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    rand_ack = 1'b0;
    wait_drain("random");
    check("final_pending", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_arbiter.md
# fib_arbiter

Round-robin arbiter that shares a single `fib` core among `NUM_REQ` requesters, each presenting its own param/result channel pair. It sits between the requesting channels and the `fib` instance. It serialises whole transactions, one param beat followed by one result beat, because `fib` holds one computation at a time. It also counts completed transactions for debug.

## Interface
- `NUM_REQ`, 4: number of requester ports, 2..8.
- `DATA_WIDTH`, 32: width of param and result data.
- `CNT_WIDTH`, 16: width of the completed-transaction counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset. Same net drives the `fib` instance.
- `req_param_data`  in  NUM_REQ*DATA_WIDTH  requester n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- `req_param_en`  in  NUM_REQ  per-requester param valid.
- `req_param_ack`  out  NUM_REQ  per-requester param accept.
- `req_result_data`  out  DATA_WIDTH  shared result data; meaningful only where `req_result_en[n]` is 1.
- `req_result_en`  out  NUM_REQ  per-requester result valid.
- `req_result_ack`  in  NUM_REQ  per-requester result accept.
- `fib_param_data`  out  DATA_WIDTH  to `fib` `channel_param_data`.
- `fib_param_en`  out  1  to `fib` `channel_param_en`.
- `fib_param_ack`  in  1  from `fib` `channel_param_ack`.
- `fib_result_data`  in  DATA_WIDTH  from `fib` `channel_result_data`.
- `fib_result_en`  in  1  from `fib` `channel_result_en`.
- `fib_result_ack`  out  1  to `fib` `channel_result_ack`.
- `grant`  out  NUM_REQ  one-hot owner of the current transaction; all zero when in IDLE.
- `done_count`  out  CNT_WIDTH  number of completed transactions; wraps modulo 2^CNT_WIDTH.

## Operation
- **Handshake.** A beat transfers on a rising edge where en=1 and ack=1. Requesters hold en and data stable until ack.
- **State machine.** Three states: IDLE, PARAM, RESULT. Registered `grant` index `g` and round-robin pointer `ptr`.
- **IDLE.**
  - If any `req_param_en` bit is set: pick the first set bit at or after `ptr` (cyclic), register `g`, go to PARAM.
  - Otherwise stay in IDLE.
- **PARAM.**
  - `fib_param_en` = `req_param_en[g]`.
  - `fib_param_data` = slice g of `req_param_data`.
  - `req_param_ack[g]` = `fib_param_ack`. All other ack bits are 0.
  - On the transfer edge, go to RESULT.
  - If `req_param_en[g]` is 0 while in PARAM (protocol violation/withdrawal): go to IDLE, set `ptr` = g+1 mod NUM_REQ, do not increment `done_count`.
- **RESULT.**
  - `req_result_en[g]` = `fib_result_en`.
  - `fib_result_ack` = `req_result_ack[g]`.
  - `req_result_data` = `fib_result_data`.
  - On the transfer edge: go to IDLE, set `ptr` = g+1 mod NUM_REQ, increment `done_count`.
- **Gating.** Non-granted requesters see ack=0 and result_en=0 at all times.
- **Reset.** IDLE, `ptr`=0, `done_count`=0. Outputs: `grant`=0, `fib_param_en`=0, `fib_result_ack`=0, all `req_*_ack`/`req_result_en`=0, data outputs 0. A reset mid-transaction aborts it; because `fib` shares `rst`, no stale result is delivered afterwards.

## Timing
- **Arbitration latency.** 1 cycle: `req_param_en` sampled high in IDLE at edge k means `fib_param_en` is high during cycle k+1.
- **Pass-through.** Once granted, channel paths are combinational: ack and en pass through with zero added latency.
- **Minimum transaction.** IDLE→PARAM→RESULT→IDLE is 3 cycles plus `fib` compute time. One dead IDLE cycle separates back-to-back transactions.
- **Simultaneous requests.** Resolved by `ptr`. With all NUM_REQ continuously requesting, grants rotate 0,1,2,…,NUM_REQ-1,0.
- **`grant`.** Registered; changes only on IDLE→PARAM and on →IDLE edges.
- **`done_count`.** Updates on the same edge as the result transfer.

## Structure
- Shared package/header holds the state encoding (IDLE=0, PARAM=1, RESULT=2) and default `DATA_WIDTH`/`CNT_WIDTH` constants.
- One sub-module, `rr_pick`: combinational cyclic first-set-bit finder. Inputs are the request vector and `ptr`; outputs are a one-hot result and an any-bit flag. It is reused by the other channel arbiters.
- FSM, grant register, channel muxing and counter live in `fib_arbiter`.

## Test plan
- **Single request.** Requester 0 sends n=6 → `grant`=0001; `req_result_en[0]` pulses with data 8; `done_count`=1.
- **Simultaneous requests.** All 4 requesters assert at once with n=0,1,2,3 → results delivered in order 0,1,2,3 with values 0,1,1,2; `done_count`=4.
- **Rotation.** Requester 2 completes, then requesters 1 and 3 request together → requester 3 is served first (`ptr`=3), then requester 1.
- **Result backpressure.** Requester 1 holds `req_result_ack`=0 for 20 cycles on n=5 → `fib_result_ack` stays 0, the FSM stays in RESULT, other requesters see no ack; on release, data 5 transfers.
- **Withdrawal.** Requester 0 drops `req_param_en` in PARAM before ack → FSM returns to IDLE, `ptr`=1, `done_count` unchanged, no `fib` activity.
- **Mid-transaction reset.** Assert `rst` for 2 cycles while in RESULT → all outputs 0 and `done_count`=0 next cycle; a subsequent n=4 request returns 3.
